// File: rtl/alu_control_mc_pkg.sv
// alu_control_mc_pkg: shared ALUOp encodings, ALU control codes and sequencer states.
package alu_ctrl_pkg;

    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_IMM = 2'b11;

    localparam logic [3:0] ADD = 4'b0010;
    localparam logic [3:0] SUB = 4'b0110;
    localparam logic [3:0] BNE = 4'b0011;
    localparam logic [3:0] MUL = 4'b1000;
    localparam logic [3:0] DIV = 4'b1001;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

endpackage

// File: rtl/alu_control_mc_if.sv
// alu_control_mc_if: decode request inputs and sequencer handshake outputs.
interface alu_control_mc_if #(
    parameter int ALUOP_W = 2,
    parameter int FUNCT_W = 4,
    parameter int CTRL_W  = 4
);
    logic               valid_in;
    logic               flush;
    logic [ALUOP_W-1:0] alu_op;
    logic [FUNCT_W-1:0] funct;
    logic [CTRL_W-1:0]  alu_ctrl;
    logic               mc_start;
    logic               mc_busy;
    logic               mc_done;
    logic               stall;

    modport master (
        output valid_in, flush, alu_op, funct,
        input  alu_ctrl, mc_start, mc_busy, mc_done, stall
    );

    modport slave (
        input  valid_in, flush, alu_op, funct,
        output alu_ctrl, mc_start, mc_busy, mc_done, stall
    );
endinterface

// File: rtl/alu_control_mc_counter.sv
// alu_mc_counter: loadable down-counter timing the iterative unit, with a zero flag.
module alu_mc_counter #(
    parameter int MC_CYCLES = 16,
    localparam int W = $clog2(MC_CYCLES + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic zero
);
    logic [W-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= W'(MC_CYCLES - 1);
        else if (en && !zero)
            cnt <= cnt - 1'b1;
    end

    assign zero = cnt == '0;
endmodule

// File: rtl/alu_control_mc.sv
// alu_control_mc: ALU control decoder with a sequencer for iterative R-type ops.
module alu_control_mc
    import alu_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 2,
    parameter int FUNCT_W = 4,
    parameter int CTRL_W  = 4,
    parameter int MC_CYCLES = 16,
    parameter logic [FUNCT_W-1:0] BNE_FUNCT = FUNCT_W'(4'b0010)
) (
    input logic clock,
    input logic reset,
    alu_control_mc_if.slave bus
);
    if (CTRL_W != FUNCT_W) begin : g_bad_width
        $error("CTRL_W must equal FUNCT_W");
    end
    if (MC_CYCLES < 1) begin : g_bad_cycles
        $error("MC_CYCLES must be at least 1");
    end

    state_t            state, next;
    logic [CTRL_W-1:0] op_reg, dec;
    logic              mc_req, accept, zero;
    logic              start_q, busy_q, done_q;

    assign mc_req = bus.valid_in && bus.alu_op == ALUOP_W'(ALUOP_R) && bus.funct[FUNCT_W-1];
    assign accept = state == IDLE && mc_req && !bus.flush;

    always_comb begin
        dec = CTRL_W'(ADD);
        dec = bus.alu_op == ALUOP_W'(ALUOP_BR) ? (bus.funct == BNE_FUNCT ? CTRL_W'(BNE) : CTRL_W'(SUB)) :
              bus.alu_op == ALUOP_W'(ALUOP_R)  ? CTRL_W'(bus.funct) : CTRL_W'(ADD);
    end

    // A held request in DONE is the finishing instruction, so DONE never re-accepts.
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = accept ? RUN : IDLE;
            RUN:     next = bus.flush ? IDLE : zero ? DONE : RUN;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            op_reg  <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= next;
            op_reg  <= accept ? CTRL_W'(bus.funct) : op_reg;
            start_q <= accept;
            busy_q  <= next == RUN;
            done_q  <= next == DONE;
        end
    end

    alu_mc_counter #(.MC_CYCLES(MC_CYCLES)) u_cnt (
        .clock (clock),
        .reset (reset),
        .load  (accept),
        .en    (state == RUN),
        .zero  (zero)
    );

    assign bus.alu_ctrl = state == IDLE ? dec : op_reg;
    assign bus.stall    = accept || state == RUN;
    assign bus.mc_start = start_q;
    assign bus.mc_busy  = busy_q;
    assign bus.mc_done  = done_q;
endmodule

// File: tb/tb_alu_control_mc.sv
// tb_alu_control_mc: scoreboard bench for decode, multi-cycle sequencing, flush and reset.
module tb_alu_control_mc;
    import alu_ctrl_pkg::*;

    localparam int MC = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   nchk  = 0;
    int   nfail = 0;
    logic [7:0] sb[$];

    alu_control_mc_if #(.ALUOP_W(2), .FUNCT_W(4), .CTRL_W(4)) bus ();

    alu_control_mc #(.MC_CYCLES(MC)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] e(logic [3:0] c, logic s, logic b, logic d, logic st);
        return {c, s, b, d, st};
    endfunction

    function automatic logic [7:0] obs();
        return {bus.alu_ctrl, bus.mc_start, bus.mc_busy, bus.mc_done, bus.stall};
    endfunction

    // Drive one cycle's inputs just after the edge and return at the following negedge.
    task automatic drive(input logic v, input logic fl, input logic [1:0] op, input logic [3:0] fn, input logic rs);
        @(posedge clock);
        #1;
        reset        = rs;
        bus.valid_in = v;
        bus.flush    = fl;
        bus.alu_op   = op;
        bus.funct    = fn;
        @(negedge clock);
    endtask

    task automatic test_reset();
        logic [7:0] x, o;
        for (int k = 0; k < 3; k++) begin
            sb.push_back(e(ADD, 0, 0, 0, 0));
            drive(0, 0, ALUOP_MEM, 4'b0000, 1);
            x = sb.pop_front();
            o = obs();
            nchk++;
            if (o !== x) begin
                nfail++;
                $display("FAIL reset[%0d]: got %b expected %b", k, o, x);
            end
        end
    endtask

    task automatic test_decode();
        logic [1:0] ops[6] = '{ALUOP_MEM, ALUOP_BR, ALUOP_BR, ALUOP_R, ALUOP_IMM, ALUOP_IMM};
        logic [3:0] fns[6] = '{4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000};
        logic [3:0] cts[6] = '{ADD, BNE, SUB, 4'b0100, ADD, ADD};
        logic [7:0] x, o;
        for (int k = 0; k < 6; k++) begin
            sb.push_back(e(cts[k], 0, 0, 0, 0));
            drive(1, 0, ops[k], fns[k], 0);
            x = sb.pop_front();
            o = obs();
            nchk++;
            if (o !== x) begin
                nfail++;
                $display("FAIL decode[%0d] op=%b fn=%b: got %b expected %b", k, ops[k], fns[k], o, x);
            end
        end
    endtask

    // One multi-cycle op issued in cycle 0; with hold the request stays up through DONE.
    task automatic test_mc(input string name, input logic [3:0] fn, input logic hold);
        logic [7:0] x, o;
        logic       req;
        for (int k = 0; k <= MC + 2; k++)
            sb.push_back(k == 0 ? e(fn, 0, 0, 0, 1) :
                         k == 1 ? e(fn, 1, 1, 0, 1) :
                         k <= MC ? e(fn, 0, 1, 0, 1) :
                         k == MC + 1 ? e(fn, 0, 0, 1, 0) : e(ADD, 0, 0, 0, 0));
        for (int k = 0; k <= MC + 2; k++) begin
            req = k == 0 || (hold && k <= MC + 1);
            drive(req, 0, req ? ALUOP_R : ALUOP_MEM, req ? fn : 4'b0000, 0);
            x = sb.pop_front();
            o = obs();
            nchk++;
            if (o !== x) begin
                nfail++;
                $display("FAIL %s[%0d]: got %b expected %b", name, k, o, x);
            end
        end
    endtask

    task automatic test_flush_run();
        logic [7:0] x, o;
        sb.push_back(e(MUL, 0, 0, 0, 1));
        sb.push_back(e(MUL, 1, 1, 0, 1));
        sb.push_back(e(MUL, 0, 1, 0, 1));
        for (int k = 3; k < MC + 4; k++) sb.push_back(e(ADD, 0, 0, 0, 0));
        for (int k = 0; k < MC + 4; k++) begin
            if (k < 3) drive(1, k == 2, ALUOP_R, MUL, 0);
            else drive(0, 0, ALUOP_MEM, 4'b0000, 0);
            x = sb.pop_front();
            o = obs();
            nchk++;
            if (o !== x) begin
                nfail++;
                $display("FAIL flush_run[%0d]: got %b expected %b", k, o, x);
            end
        end
    endtask

    task automatic test_flush_idle();
        logic [7:0] x, o;
        sb.push_back(e(MUL, 0, 0, 0, 0));
        sb.push_back(e(ADD, 0, 0, 0, 0));
        sb.push_back(e(ADD, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++) begin
            if (k == 0) drive(1, 1, ALUOP_R, MUL, 0);
            else drive(0, 0, ALUOP_MEM, 4'b0000, 0);
            x = sb.pop_front();
            o = obs();
            nchk++;
            if (o !== x) begin
                nfail++;
                $display("FAIL flush_idle[%0d]: got %b expected %b", k, o, x);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] x, o;
        sb.push_back(e(DIV, 0, 0, 0, 1));
        sb.push_back(e(DIV, 1, 1, 0, 1));
        sb.push_back(e(DIV, 0, 1, 0, 1));
        sb.push_back(e(ADD, 0, 0, 0, 0));
        sb.push_back(e(ADD, 0, 0, 0, 0));
        for (int k = 0; k < 5; k++) begin
            if (k == 0) drive(1, 0, ALUOP_R, DIV, 0);
            else drive(0, 0, ALUOP_MEM, 4'b0000, k == 2);
            x = sb.pop_front();
            o = obs();
            nchk++;
            if (o !== x) begin
                nfail++;
                $display("FAIL reset_mid[%0d]: got %b expected %b", k, o, x);
            end
        end
        test_mc("mul_after_reset", MUL, 0);
    endtask

    initial begin
        bus.valid_in = 1'b0;
        bus.flush    = 1'b0;
        bus.alu_op   = ALUOP_MEM;
        bus.funct    = 4'b0000;
        test_reset();
        test_decode();
        test_mc("mul", MUL, 0);
        test_mc("div_held", DIV, 1);
        test_flush_run();
        test_flush_idle();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
